// File: rtl/run_sequencer_if.sv
// Debug run/halt sequencer signal bundle: board controls, pipeline taps and status.
// Combinational wiring only, no latency.
// No backpressure; every signal is a plain level.
interface run_sequencer_if #(
  parameter int PC_W   = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
);
  logic              go;
  logic [1:0]        mode;
  logic [STEP_W-1:0] n_steps;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]   pc;
  logic              halt_req;
  logic              clr_cnt;
  logic              cpu_en;
  logic              halted;
  logic [2:0]        halt_cause;
  logic [STEP_W-1:0] steps_left;
  logic [CNT_W-1:0]  cycle_cnt;

  // Board / pipeline side: drives controls, observes the enable and status.
  modport master (
    output go, mode, n_steps, bp_en, bp_addr, pc, halt_req, clr_cnt,
    input  cpu_en, halted, halt_cause, steps_left, cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  go, mode, n_steps, bp_en, bp_addr, pc, halt_req, clr_cnt,
    output cpu_en, halted, halt_cause, steps_left, cycle_cnt
  );
endinterface

// File: rtl/run_sequencer.sv
// Debug run/halt sequencer producing the pipeline-wide clock enable.
// Latency: cpu_en is registered; a go edge enables the pipeline from the next cycle.
// No backpressure; halt_req or a go edge while running freezes the pipeline next cycle.
module run_sequencer #(
  parameter int PC_W   = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            rst,
  run_sequencer_if.slave dbg
);

  localparam logic [2:0] CAUSE_RESET   = 3'd0;
  localparam logic [2:0] CAUSE_SYSCALL = 3'd1;
  localparam logic [2:0] CAUSE_STEP    = 3'd2;
  localparam logic [2:0] CAUSE_COUNT   = 3'd3;
  localparam logic [2:0] CAUSE_BREAK   = 3'd4;
  localparam logic [2:0] CAUSE_ABORT   = 3'd5;

  typedef enum logic [2:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_RUNN,
    S_BRK
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              go_q;
  logic              go_rise;
  logic              first_q;
  logic              bp_en_q;
  logic [PC_W-1:0]   bp_addr_q;
  logic              bp_hit;
  logic              start;
  logic              cause_ld;
  logic [2:0]        cause_nx;
  logic [2:0]        cause_q;
  logic              cpu_en_q;
  logic [STEP_W-1:0] steps_q;
  logic [CNT_W-1:0]  cnt_q;

  assign go_rise = dbg.go & ~go_q;

  // The first enabled cycle after a start never breaks, so a resume can step off the bp.
  assign bp_hit = bp_en_q & (dbg.pc == bp_addr_q) & ~first_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HALT;
    else     state <= state_nx;
  end

  // Start decode from HALT and prioritised halt decision while running.
  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    cause_ld = 1'b0;
    start    = 1'b0;
    if (state == S_HALT) begin
      if (go_rise) begin
        start = 1'b1;
        case (dbg.mode)
          2'b00:   state_nx = S_RUN;
          2'b01:   state_nx = S_STEP;
          2'b10:   state_nx = S_RUNN;
          default: state_nx = S_BRK;
        endcase
      end
    end else begin
      cause_ld = 1'b1;
      state_nx = S_HALT;
      if (dbg.halt_req)                               cause_nx = CAUSE_SYSCALL;
      else if (go_rise)                               cause_nx = CAUSE_ABORT;
      else if (state == S_BRK && bp_hit)              cause_nx = CAUSE_BREAK;
      else if (state == S_STEP)                       cause_nx = CAUSE_STEP;
      else if (state == S_RUNN && steps_q == STEP_W'(1)) cause_nx = CAUSE_COUNT;
      else begin
        cause_ld = 1'b0;
        state_nx = state;
      end
    end
  end

  // go edge history and breakpoint captured at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q      <= 1'b0;
      first_q   <= 1'b0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
    end else begin
      go_q    <= dbg.go;
      first_q <= start;
      if (start) begin
        bp_en_q   <= dbg.bp_en;
        bp_addr_q <= dbg.bp_addr;
      end
    end
  end

  // Registered pipeline enable, glitch-free for every stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu_en_q <= 1'b0;
    else     cpu_en_q <= (state_nx != S_HALT);
  end

  // Run-N remaining count: loaded at start (0 runs once), zero outside run-N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       steps_q <= '0;
    else if (state_nx != S_RUNN)   steps_q <= '0;
    else if (start)                steps_q <= (dbg.n_steps == '0) ? STEP_W'(1) : dbg.n_steps;
    else                           steps_q <= steps_q - STEP_W'(1);
  end

  // Halt cause is only rewritten on the next halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cause_q <= CAUSE_RESET;
    else if (cause_ld) cause_q <= cause_nx;
  end

  // Enabled-cycle counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (dbg.clr_cnt) cnt_q <= '0;
    else if (cpu_en_q)    cnt_q <= cnt_q + CNT_W'(1);
  end

  assign dbg.cpu_en     = cpu_en_q;
  assign dbg.halted     = ~cpu_en_q;
  assign dbg.halt_cause = cause_q;
  assign dbg.steps_left = steps_q;
  assign dbg.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios plus random stimulus vs a cycle model.
// Inputs change 1 time unit after each rising edge; outputs are compared there too.
// Counter width is reduced so wrap-around is reachable.
module tb_run_sequencer;
  localparam int PC_W   = 32;
  localparam int STEP_W = 16;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  run_sequencer_if #(.PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dbg();

  run_sequencer #(.PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg.slave)
  );

  int errors = 0;
  int checks = 0;
  int en_seen = 0;

  // Reference model: "is the pipeline running, in which run kind, and what is left".
  bit              m_en;
  int              m_kind;
  int              m_left;
  logic [PC_W-1:0] m_bp;
  bit              m_bpen;
  bit              m_first;
  bit              m_go_prev;
  logic [2:0]      m_cause;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_kind = 0; m_left = 0; m_bp = '0; m_bpen = 0;
    m_first = 0; m_go_prev = 0; m_cause = 3'd0; m_cnt = '0;
  endtask

  // One clock edge of the run/halt rules, using the inputs present at that edge.
  task automatic model_step();
    bit rise;
    int c;
    rise = dbg.go && !m_go_prev;
    m_go_prev = dbg.go;
    if (dbg.clr_cnt) m_cnt = '0;
    else if (m_en)   m_cnt = m_cnt + 1'b1;
    if (!m_en) begin
      if (rise) begin
        m_en    = 1;
        m_kind  = int'(dbg.mode);
        m_left  = (m_kind == 2) ? ((dbg.n_steps == 0) ? 1 : int'(dbg.n_steps)) : 0;
        m_bp    = dbg.bp_addr;
        m_bpen  = dbg.bp_en;
        m_first = 1;
      end
    end else begin
      c = -1;
      if (dbg.halt_req)                                      c = 1;
      else if (rise)                                         c = 5;
      else if (m_kind == 3 && m_bpen && dbg.pc == m_bp && !m_first) c = 4;
      else if (m_kind == 1)                                  c = 2;
      else if (m_kind == 2 && m_left == 1)                   c = 3;
      if (c >= 0) begin
        m_en = 0;
        m_cause = 3'(c);
        m_left = 0;
      end else begin
        if (m_kind == 2) m_left--;
        m_first = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("cpu_en",     64'(dbg.cpu_en),     64'(m_en));
    check("halted",     64'(dbg.halted),     64'(!m_en));
    check("halt_cause", 64'(dbg.halt_cause), 64'(m_cause));
    check("steps_left", 64'(dbg.steps_left), 64'(m_left));
    check("cycle_cnt",  64'(dbg.cycle_cnt),  64'(m_cnt));
  endtask

  // Advance one cycle; the IF-stage PC moves by 4 only in enabled cycles.
  task automatic tick();
    bit was_en;
    @(posedge clk);
    was_en = m_en;
    model_step();
    #1;
    if (was_en) dbg.pc = dbg.pc + 32'd4;
    if (dbg.cpu_en) en_seen++;
    compare_all();
  endtask

  task automatic go_pulse();
    dbg.go = 1'b1;
    tick();
    dbg.go = 1'b0;
    tick();
  endtask

  task automatic clear_cnt();
    dbg.clr_cnt = 1'b1;
    tick();
    dbg.clr_cnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dbg.go = 0; dbg.mode = 0; dbg.n_steps = 0; dbg.bp_en = 0;
    dbg.bp_addr = '0; dbg.pc = 32'h0040_0000; dbg.halt_req = 0; dbg.clr_cnt = 0;
    model_reset();
    #1;
    check("rst_cpu_en", 64'(dbg.cpu_en), 64'd0);
    check("rst_halted", 64'(dbg.halted), 64'd1);
    check("rst_cause",  64'(dbg.halt_cause), 64'd0);
    check("rst_steps",  64'(dbg.steps_left), 64'd0);
    check("rst_cnt",    64'(dbg.cycle_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Single step: exactly one enabled cycle.
    dbg.mode = 2'b01;
    clear_cnt();
    en_seen = 0;
    go_pulse();
    repeat (3) tick();
    check("step_en_cycles", 64'(en_seen), 64'd1);
    check("step_cause", 64'(dbg.halt_cause), 64'd2);
    check("step_cnt", 64'(dbg.cycle_cnt), 64'd1);

    // Run-N with N=5, then N=0 behaving as N=1.
    dbg.mode = 2'b10; dbg.n_steps = 16'd5;
    en_seen = 0;
    go_pulse();
    dbg.n_steps = 16'd9;
    repeat (8) tick();
    check("runn5_en_cycles", 64'(en_seen), 64'd5);
    check("runn5_cause", 64'(dbg.halt_cause), 64'd3);
    check("runn5_left", 64'(dbg.steps_left), 64'd0);
    dbg.n_steps = 16'd0;
    en_seen = 0;
    go_pulse();
    repeat (3) tick();
    check("runn0_en_cycles", 64'(en_seen), 64'd1);

    // Run to breakpoint, resume from the bp address, then abort.
    dbg.mode = 2'b11; dbg.bp_en = 1; dbg.bp_addr = 32'h0040_0010;
    dbg.pc = 32'h0040_0000;
    en_seen = 0;
    go_pulse();
    repeat (10) tick();
    check("brk_en_cycles", 64'(en_seen), 64'd5);
    check("brk_cause", 64'(dbg.halt_cause), 64'd4);
    dbg.pc = 32'h0040_0010;
    go_pulse();
    repeat (6) tick();
    check("brk_resume_running", 64'(dbg.cpu_en), 64'd1);
    go_pulse();
    check("abort_cause", 64'(dbg.halt_cause), 64'd5);
    check("abort_halted", 64'(dbg.halted), 64'd1);
    dbg.bp_en = 0;

    // Syscall beats abort; held syscall allows one cycle per resume.
    dbg.mode = 2'b00;
    go_pulse();
    repeat (2) tick();
    dbg.halt_req = 1; dbg.go = 1;
    tick();
    dbg.go = 0;
    tick();
    check("sys_vs_abort_cause", 64'(dbg.halt_cause), 64'd1);
    en_seen = 0;
    go_pulse();
    repeat (3) tick();
    check("sys_resume_en_cycles", 64'(en_seen), 64'd1);
    check("sys_resume_cause", 64'(dbg.halt_cause), 64'd1);
    dbg.halt_req = 0;

    // Counter wrap and clear while enabled.
    clear_cnt();
    dbg.go = 1;
    tick();
    dbg.go = 0;
    repeat (255) tick();
    check("cnt_max", 64'(dbg.cycle_cnt), 64'd255);
    tick();
    check("cnt_wrap", 64'(dbg.cycle_cnt), 64'd0);
    repeat (3) tick();
    clear_cnt();
    check("cnt_clr_running_en", 64'(dbg.cpu_en), 64'd1);
    check("cnt_clr_running", 64'(dbg.cycle_cnt), 64'd0);

    // Asynchronous reset mid-run takes effect without a clock edge.
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_cpu_en", 64'(dbg.cpu_en), 64'd0);
    check("midrst_cause", 64'(dbg.halt_cause), 64'd0);
    check("midrst_cnt", 64'(dbg.cycle_cnt), 64'd0);
    model_reset();
    #1 rst = 1'b0;
    tick();

    // Random mix of all modes, breakpoints, syscalls, aborts and clears.
    for (int i = 0; i < 600; i++) begin
      dbg.go       = ($urandom_range(0, 7) == 0);
      dbg.mode     = 2'($urandom_range(0, 3));
      dbg.n_steps  = 16'($urandom_range(0, 6));
      dbg.bp_en    = ($urandom_range(0, 3) != 0);
      dbg.bp_addr  = dbg.pc + 32'(4 * $urandom_range(0, 6));
      dbg.halt_req = ($urandom_range(0, 24) == 0);
      dbg.clr_cnt  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) dbg.pc = {$urandom_range(0, 255), 2'b00};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
